// File: rtl/ps2_keypad_decoder.sv
// PS/2 keypad scan-code decoder: turns make/break byte sequences into digit events queued in a FIFO.
// Optional macro KP_RELEASE_EVENT_EN also queues release events, flagged by key_release.
module ps2_keypad_decoder #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       ck,
   input  logic       reset,
   input  logic [7:0] ps2_key_code,
   input  logic       key_ready,
   output logic       key_valid,
   output logic [3:0] key_digit,
   output logic       key_release,
   output logic       key_down,
   output logic [3:0] held_digit,
   output logic       overflow
);

   // Scan-code values shared with PS2_Keyboard (keycodes.vh).
   localparam logic [7:0] KP_0            = 8'h70;
   localparam logic [7:0] KP_1            = 8'h69;
   localparam logic [7:0] KP_2            = 8'h72;
   localparam logic [7:0] KP_3            = 8'h7A;
   localparam logic [7:0] KP_4            = 8'h6B;
   localparam logic [7:0] KP_5            = 8'h73;
   localparam logic [7:0] KP_6            = 8'h74;
   localparam logic [7:0] KP_7            = 8'h6C;
   localparam logic [7:0] KP_8            = 8'h75;
   localparam logic [7:0] KP_9            = 8'h7D;
   localparam logic [7:0] KP_KEY_RELEASED = 8'hF0;
   localparam logic [7:0] KP_INVALID      = 8'hFF;

`ifdef KP_RELEASE_EVENT_EN
   localparam int unsigned EW = 5;
`else
   localparam int unsigned EW = 4;
`endif

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of 2 and at least 2");
   end

   typedef enum logic {
      S_IDLE,
      S_BREAK
   } state_t;

   // ------------------------------------------------------------------
   // Input stage: the source holds each byte as a level, so a change of
   // value is the only sign that a new byte arrived.
   // ------------------------------------------------------------------
   logic [7:0] code_r;
   logic [7:0] code_prev;
   logic       byte_event;

   always_ff @(posedge ck) begin
      if (reset) begin
         code_r    <= '0;
         code_prev <= '0;
      end else begin
         code_r    <= ps2_key_code;
         code_prev <= code_r;
      end
   end

   assign byte_event = (code_r != code_prev);

   logic       code_is_digit;
   logic [3:0] code_digit;

   always_comb begin
      code_is_digit = 1'b1;
      code_digit    = '0;
      case (code_r)
         KP_0:    code_digit = 4'd0;
         KP_1:    code_digit = 4'd1;
         KP_2:    code_digit = 4'd2;
         KP_3:    code_digit = 4'd3;
         KP_4:    code_digit = 4'd4;
         KP_5:    code_digit = 4'd5;
         KP_6:    code_digit = 4'd6;
         KP_7:    code_digit = 4'd7;
         KP_8:    code_digit = 4'd8;
         KP_9:    code_digit = 4'd9;
         default: code_is_digit = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Make/break FSM
   // ------------------------------------------------------------------
   state_t          state;
   state_t          state_next;
   logic            key_down_r;
   logic            key_down_next;
   logic [3:0]      held_r;
   logic [3:0]      held_next;
   logic            push;
   logic [EW-1:0]   push_entry;

   always_ff @(posedge ck) begin
      if (reset) begin
         state      <= S_IDLE;
         key_down_r <= 1'b0;
         held_r     <= '0;
      end else begin
         state      <= state_next;
         key_down_r <= key_down_next;
         held_r     <= held_next;
      end
   end

   always_comb begin
      state_next    = state;
      key_down_next = key_down_r;
      held_next     = held_r;
      push          = 1'b0;
      push_entry    = '0;
      if (byte_event) begin
         case (state)
            S_IDLE: begin
               if (code_is_digit) begin
                  push          = 1'b1;
`ifdef KP_RELEASE_EVENT_EN
                  push_entry    = {1'b0, code_digit};
`else
                  push_entry    = code_digit;
`endif
                  key_down_next = 1'b1;
                  held_next     = code_digit;
               end else if (code_r == KP_KEY_RELEASED) begin
                  state_next = S_BREAK;
               end
            end
            S_BREAK: begin
               if (code_is_digit) begin
                  // Only the key actually held is released; a stale break is ignored.
                  if (key_down_r && (code_digit == held_r)) begin
                     key_down_next = 1'b0;
                  end
`ifdef KP_RELEASE_EVENT_EN
                  push       = 1'b1;
                  push_entry = {1'b1, code_digit};
`endif
                  state_next = S_IDLE;
               end else if (code_r != KP_KEY_RELEASED) begin
                  state_next = S_IDLE;
               end
            end
            default: state_next = S_IDLE;
         endcase
      end
   end

   assign key_down   = key_down_r;
   assign held_digit = held_r;

   // ------------------------------------------------------------------
   // Event FIFO: pointers carry one extra wrap bit to tell full from empty.
   // ------------------------------------------------------------------
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          fifo_empty;
   logic          fifo_full;
   logic          pop;
   logic          wr_en;
   logic          drop;
   logic          overflow_r;
   logic [EW-1:0] head;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop        = !fifo_empty && key_ready;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign wr_en      = push && (!fifo_full || pop);
   assign drop       = push && fifo_full && !pop;

   always_ff @(posedge ck) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow_r <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (drop) begin
            overflow_r <= 1'b1;
         end
      end
   end

   always_ff @(posedge ck) begin
      if (!reset && wr_en) begin
         mem[wr_ptr[AW-1:0]] <= push_entry;
      end
   end

   assign head      = mem[rd_ptr[AW-1:0]];
   assign key_valid = !fifo_empty;
   assign key_digit = fifo_empty ? 4'd0 : head[3:0];
   assign overflow  = overflow_r;

`ifdef KP_RELEASE_EVENT_EN
   assign key_release = fifo_empty ? 1'b0 : head[4];
`else
   assign key_release = 1'b0;
`endif

endmodule
